// File: rtl/mem_responder.sv
// Memory-side responder for the my_mem_if bus: parity-tagged storage, poison on unwritten
// locations, conflict counting. Define MEM_RESP_PARITY_CHECK_EN to reject bad-parity writes.
module mem_responder #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH_W  = 8,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        data_in,
    input  logic              parity,
    output logic [8:0]        data_out,
    output logic              rd_valid,
    output logic              rw_conflict,
    output logic [CNT_W-1:0]  rw_err_cnt,
    output logic              par_err,
    output logic [CNT_W-1:0]  par_err_cnt
);

    localparam int unsigned NUM_LOC = 1 << DEPTH_W;
    localparam logic [8:0]  POISON  = 9'h1FF;

    logic [8:0]         mem [NUM_LOC];
    logic [NUM_LOC-1:0] valid;
    logic [8:0]         pipe_data [READ_LAT];
    logic [READ_LAT-1:0] pipe_vld;

    logic               wr_req;
    logic               rd_req;
    logic               conflict;
    logic               in_range;
    logic               par_ok;
    logic               wr_commit;
    logic [DEPTH_W-1:0] idx;
    logic [8:0]         rd_word;

    always_comb begin
        wr_req   = write & ~read;
        rd_req   = read & ~write;
        conflict = read & write;
        // Compare one bit wider so DEPTH_W == ADDR_W needs no special case.
        in_range = ({1'b0, address} < (ADDR_W+1)'(NUM_LOC));
        idx      = address[DEPTH_W-1:0];
`ifdef MEM_RESP_PARITY_CHECK_EN
        par_ok   = (parity == ^data_in);
`else
        par_ok   = 1'b1;
`endif
        wr_commit = wr_req & in_range & par_ok;
        rd_word   = (in_range && valid[idx]) ? mem[idx] : POISON;
    end

    // Array contents deliberately survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wr_commit) begin
            mem[idx] <= {parity, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_commit) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_req;
            pipe_data[0] <= rd_word;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pipe_vld[READ_LAT-1];
            if (pipe_vld[READ_LAT-1]) begin
                data_out <= pipe_data[READ_LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_conflict <= 1'b0;
            rw_err_cnt  <= '0;
        end else begin
            rw_conflict <= conflict;
            if (conflict && (rw_err_cnt != '1)) begin
                rw_err_cnt <= rw_err_cnt + CNT_W'(1);
            end
        end
    end

`ifdef MEM_RESP_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err     <= 1'b0;
            par_err_cnt <= '0;
        end else begin
            par_err <= wr_req & ~par_ok;
            if (wr_req && !par_ok && (par_err_cnt != '1)) begin
                par_err_cnt <= par_err_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign par_err     = 1'b0;
    assign par_err_cnt = '0;
`endif

endmodule
